// File: rtl/sum_accumulator.sv
// Accumulates 5-bit adder results ({OvfIn,SumIn}) into an 8-bit group total.
// Groups end on SumLast. The result is held until the consumer acknowledges it.
module sum_accumulator (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] SumIn,
  input  logic       OvfIn,
  input  logic       SumValid,
  input  logic       SumLast,
  output logic       SumReady,
  input  logic       ResAck,
  output logic [7:0] Total,
  output logic [3:0] Count,
  output logic       Sticky,
  output logic       ResValid,
  output logic       Done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0] state;
  logic [1:0] nextState;
  logic       transfer;
  logic [7:0] operand;
  logic [8:0] sumWide;

  assign operand  = {3'b000, OvfIn, SumIn};
  assign sumWide  = {1'b0, Total} + {1'b0, operand};
  assign SumReady = !rst && (state != HOLD);
  assign transfer = SumValid && SumReady;
  assign ResValid = (state == HOLD);

  always_comb begin
    nextState = state;
    case (state)
      IDLE, ACCUM: begin
        if (transfer) begin
          nextState = SumLast ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (ResAck) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The first operand of a group seeds the registers; later ones add with wrap tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      Total  <= 8'd0;
      Count  <= 4'd0;
      Sticky <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state <= nextState;
      Done  <= (nextState == HOLD) && (state != HOLD);
      if (transfer && (state == IDLE)) begin
        Total  <= operand;
        Count  <= 4'd1;
        Sticky <= 1'b0;
      end else if (transfer && (state == ACCUM)) begin
        Total  <= sumWide[7:0];
        Sticky <= Sticky | sumWide[8];
        Count  <= (Count == 4'hF) ? Count : Count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: an unbounded-arithmetic group model checked on every
// falling edge, directed scenarios pinned with literal results, then random traffic.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] SumIn = 4'd0;
  logic       OvfIn = 1'b0;
  logic       SumValid = 1'b0;
  logic       SumLast = 1'b0;
  logic       ResAck = 1'b0;
  logic       SumReady;
  logic [7:0] Total;
  logic [3:0] Count;
  logic       Sticky;
  logic       ResValid;
  logic       Done;

  int nVectors = 0;
  int nMiscompares = 0;
  bit checkEn = 1'b0;

  // Model: a group is a plain integer sum and operand count.
  bit mHold = 1'b0;
  bit mOpen = 1'b0;
  bit mDone = 1'b0;
  int mSum = 0;
  int mN = 0;

  sum_accumulator dut (
    .clk(clk),
    .rst(rst),
    .SumIn(SumIn),
    .OvfIn(OvfIn),
    .SumValid(SumValid),
    .SumLast(SumLast),
    .SumReady(SumReady),
    .ResAck(ResAck),
    .Total(Total),
    .Count(Count),
    .Sticky(Sticky),
    .ResValid(ResValid),
    .Done(Done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mHold <= 1'b0;
      mOpen <= 1'b0;
      mSum  <= 0;
      mN    <= 0;
      mDone <= 1'b0;
    end else begin
      mDone <= 1'b0;
      if (mHold) begin
        if (ResAck) mHold <= 1'b0;
      end else if (SumValid) begin
        if (!mOpen) begin
          mSum <= int'({OvfIn, SumIn});
          mN   <= 1;
        end else begin
          mSum <= mSum + int'({OvfIn, SumIn});
          mN   <= mN + 1;
        end
        mOpen <= !SumLast;
        mHold <= SumLast;
        mDone <= SumLast;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("SumReady", {7'd0, SumReady}, {7'd0, (!rst && !mHold)});
      checkOutput("Total", Total, 8'(mSum % 256));
      checkOutput("Count", {4'd0, Count}, 8'((mN > 15) ? 15 : mN));
      checkOutput("Sticky", {7'd0, Sticky}, {7'd0, (mSum >= 256)});
      checkOutput("ResValid", {7'd0, ResValid}, {7'd0, mHold});
      checkOutput("Done", {7'd0, Done}, {7'd0, mDone});
    end
  end

  task automatic applyStimulus(input bit r, input bit v, input logic [4:0] op, input bit last, input bit ack);
    rst      = r;
    SumValid = v;
    {OvfIn, SumIn} = op;
    SumLast  = last;
    ResAck   = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held for two cycles, ready must stay low throughout.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("ReadyInReset", {7'd0, SumReady}, 8'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ReadyAfterReset", {7'd0, SumReady}, 8'd1);
    checkOutput("TotalAfterReset", Total, 8'h00);
    checkOutput("ResValidAfterReset", {7'd0, ResValid}, 8'd0);

    // Single operand {1,A}.
    applyStimulus(1'b0, 1'b1, 5'h1A, 1'b1, 1'b0);
    rst = 1'b0; SumValid = 1'b0; SumLast = 1'b0;
    @(negedge clk);
    checkOutput("SingleTotal", Total, 8'h1A);
    checkOutput("SingleCount", {4'd0, Count}, 8'd1);
    checkOutput("SingleDone", {7'd0, Done}, 8'd1);
    idle(2);
    checkOutput("SingleHeld", {7'd0, ResValid}, 8'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(1);

    // Three operands with a two-cycle gap.
    applyStimulus(1'b0, 1'b1, 5'h05, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 5'h07, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'h0F, 1'b1, 1'b0);
    SumValid = 1'b0; SumLast = 1'b0;
    @(negedge clk);
    checkOutput("ThreeTotal", Total, 8'h1B);
    checkOutput("ThreeCount", {4'd0, Count}, 8'd3);
    checkOutput("ThreeSticky", {7'd0, Sticky}, 8'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    // 17 x 31 = 527 wraps to 0x0F with count saturated.
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 5'h1F, (i == 16), 1'b0);
    // Operand 3 held against backpressure during HOLD.
    applyStimulus(1'b0, 1'b1, 5'h03, 1'b1, 1'b0);
    checkOutput("WrapTotal", Total, 8'h0F);
    checkOutput("WrapCount", {4'd0, Count}, 8'd15);
    checkOutput("WrapSticky", {7'd0, Sticky}, 8'd1);
    checkOutput("BackpressReady", {7'd0, SumReady}, 8'd0);
    applyStimulus(1'b0, 1'b1, 5'h03, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'h03, 1'b1, 1'b0);
    checkOutput("BackpressTotal", Total, 8'h03);
    checkOutput("BackpressSticky", {7'd0, Sticky}, 8'd0);
    // Ack in the Done cycle ends HOLD after one cycle.
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("AckOnDone", {7'd0, ResValid}, 8'd0);

    // Reset mid-group discards the partial sum and beats a same-cycle transfer.
    applyStimulus(1'b0, 1'b1, 5'h04, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'h06, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'h09, 1'b1, 1'b0);
    idle(1);
    checkOutput("MidResetTotal", Total, 8'h00);
    checkOutput("MidResetCount", {4'd0, Count}, 8'd0);
    checkOutput("MidResetDone", {7'd0, Done}, 8'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
                    5'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 1) == 1));
    end
    idle(2);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 SumIn  input  4  sum bits from the 4-bit adder stage.
REQ-005 OvfIn  input  1  carry-out (overflow) from the adder stage; weight 16.
REQ-006 SumValid  input  1  SumIn/OvfIn/SumLast valid this cycle.
REQ-007 SumLast  input  1  marks the final operand of a group; sampled only on transfer.
REQ-008 SumReady  output  1  block can accept an operand this cycle.
REQ-009 ResAck  input  1  downstream consumed the result.
REQ-010 Total  output  8  running total of the group, modulo 256.
REQ-011 Count  output  4  operands accepted in the group, saturating at 15.
REQ-012 Sticky  output  1  set if Total wrapped past 255 at any point in the group.
REQ-013 ResValid  output  1  Total/Count/Sticky hold a completed group result.
REQ-014 Done  output  1  one-cycle pulse on result completion.

Function
REQ-015 Transfer SHALL occur on a rising clk edge where SumValid=1 and SumReady=1; no other condition accepts data.
REQ-016 Operand value SHALL be {OvfIn,SumIn}, 5 bits (0..31), zero-extended to 8 bits.
REQ-017 FSM SHALL have states IDLE, ACCUM and HOLD, encoded in registers.
REQ-018 SumReady SHALL be 1 in IDLE and ACCUM, 0 in HOLD, and 0 while rst=1 (combinational).
REQ-019 IDLE, transfer: Total<=value, Count<=1, Sticky<=0; next state HOLD if SumLast=1, else ACCUM.
REQ-020 ACCUM, transfer: Total<=(Total+value) mod 256; Sticky<=1 if the 9-bit sum exceeds 255, else unchanged; Count<=Count+1, holding at 15; next state HOLD if SumLast=1, else stay in ACCUM.
REQ-021 ACCUM with no transfer SHALL hold all registers and remain in ACCUM (no timeout).
REQ-022 ResValid SHALL be 1 exactly while in HOLD.
REQ-023 Done SHALL be 1 only in the first HOLD cycle (registered, one cycle after the SumLast transfer).
REQ-024 HOLD: ResAck=1 SHALL move to IDLE on that edge; Total/Count/Sticky SHALL hold until overwritten by the next IDLE transfer.
REQ-025 ResAck outside HOLD SHALL be ignored.
REQ-026 SumValid in HOLD SHALL NOT be accepted; upstream holds the operand until SumReady returns (first IDLE cycle after ack).
REQ-027 Latency: operand at transfer edge N SHALL be reflected in Total after edge N (visible in cycle N+1); accumulation throughput is one operand per cycle.
REQ-028 ResAck in the same cycle Done is asserted SHALL be honoured (HOLD lasts one cycle).

Reset
REQ-029 With rst=1 at a clk edge, state<=IDLE, Total<=0, Count<=0, Sticky<=0, Done<=0; ResValid=0 follows from state.
REQ-030 Reset SHALL take priority over transfer and ResAck in the same cycle; a partial group is discarded.
REQ-031 Reset values SHALL hold until the first transfer after rst deasserts.

Verification
REQ-032 Reset: hold rst 2 cycles, then release -> Total=0, Count=0, Sticky=0, Done=0, ResValid=0; SumReady=0 during reset and 1 on the first cycle after.
REQ-033 Single operand: SumIn=4'hA, OvfIn=1, SumLast=1 -> next cycle Total=8'h1A, Count=1, Sticky=0, Done=1 for one cycle; ResValid=1 until ResAck, then 0.
REQ-034 Three-operand group: SumIn 5, 7, F (OvfIn=0), SumLast on the third; SumValid dropped for 2 cycles between the 1st and 2nd operands -> Total=8'h1B, Count=3, Sticky=0.
REQ-035 Wrap and saturation: 17 operands of {1,F}=31 -> Total=8'h0F, Count=15, Sticky=1.
REQ-036 Backpressure: SumValid held high with operand 3 during HOLD -> SumReady=0 and no change to Total; after ResAck, the operand is accepted in the first IDLE cycle, giving Total=8'h03 and Sticky cleared.
REQ-037 Reset mid-group: 2 operands (4, 6) accepted in ACCUM, then rst pulsed for 1 cycle -> Total=0, Count=0, state IDLE, no Done pulse.
